seq_detect_mealy: RTL and testbench
===================================

Name: seq_detect_mealy

Overview:
- Parametrised Mealy sequence detector. It matches a runtime-programmable pattern of LEN symbols, each SYM_W bits wide, with a per-bit don't-care mask.
- It is the general successor to the team's fixed 2-input, hard-coded-equation Mealy detectors. It adds overlap/non-overlap mode, arming control, a registered match copy and a saturating match counter.
- It sits between a synchronised input sampler and the lab display/counter logic.

Parameters:
- SYM_W, 2, bits per input symbol (>=1).
- LEN, 3, symbols in the pattern (>=2).
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low: 0 resets the block immediately.
- cfg_load  in  1  latches the cfg_* inputs and arms the detector.
- cfg_pattern  in  LEN*SYM_W  pattern. Symbol k is bits [k*SYM_W +: SYM_W]; k=0 is the oldest symbol.
- cfg_mask  in  LEN*SYM_W  1 = bit compared, 0 = don't care.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- en  in  1  0 disarms the detector (IDLE).
- sym_valid  in  1  a symbol is presented this cycle.
- sym  in  SYM_W  input symbol.
- cnt_clr  in  1  synchronous clear of match_cnt.
- y  out  1  Mealy match, combinational, same cycle as the last symbol.
- y_q  out  1  y registered (one cycle later).
- fill  out  $clog2(LEN)  number of valid history symbols held.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; history, fill, y_q, match_cnt = 0.
  - Pattern/mask registers = 0, overlap = 0.
  - y = 0, because y is gated by the ARMED state.
- States:
  - IDLE: symbols are ignored and y=0.
  - ARMED: symbols are accepted.
- IDLE -> ARMED: on cfg_load=1 with en=1.
- ARMED -> IDLE: on en=0. fill is cleared on the next edge.
- cfg_load in ARMED:
  - re-latches the configuration and clears the history (fill<=0);
  - the symbol presented in the same cycle is discarded, and y=0 that cycle.
- cfg_load with en=0: latches the configuration only; the state stays IDLE.
- History: an LEN-1 deep shift register of accepted symbols.
- Window (oldest to newest) = history entries, then the current sym.
- Match, y = 1 when all of the following hold:
  - state is ARMED;
  - sym_valid=1;
  - cfg_load=0;
  - fill == LEN-1;
  - for every k: ((window[k] XOR pat[k]) AND mask[k]) == 0.
- On each accepted symbol (ARMED, sym_valid, !cfg_load):
  - the history shifts in sym;
  - fill <= min(fill+1, LEN-1).
  - Exception: if y=1 and overlap=0, fill <= 0, so the next match needs LEN fresh symbols.
- sym_valid=0: the history, fill and y hold/stay 0. Gaps between symbols are allowed and do not break a partial match.
- y_q <= y every cycle.
- match_cnt:
  - increments by 1 when y=1;
  - saturates at 2^CNT_W-1 (no wrap);
  - cnt_clr=1 forces 0, and a match in the same cycle is not counted (clear wins).
- A mask entirely zero matches any LEN-symbol window once fill is full.
- Latency:
  - y: 0 cycles from the final symbol;
  - y_q and match_cnt update: 1 cycle.

Decomposition:
- Shared package seq_detect_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_ARMED=1'b1;
  - a function sym_match(sym, pat, mask) returning 1 bit.
- One natural sub-module: seq_hist_shreg (parametrised SYM_W x DEPTH shift register with synchronous clear, enable and asynchronous active-low reset). It is reused elsewhere for input histories.
- Compare and counter logic stay in the top module.

Test Plan:
Common setup unless stated: SYM_W=2, LEN=3, pattern 10,01,11, mask all ones.
1. Reset and arm: rst low mid-stream -> all outputs 0 immediately. Release, cfg_load+en -> next cycle ARMED, fill=0.
2. Basic match, overlap=0: feed 10,01,11 on consecutive cycles -> y=1 only in cycle 3; y_q=1 in cycle 4; match_cnt=1; fill=0 after the match.
3. Overlap: pattern 11,11,11, feed six 11 symbols.
   - overlap=1 -> y in cycles 3-6, match_cnt=4.
   - overlap=0 -> y in cycles 3 and 6, match_cnt=2.
4. Gaps, mask and mismatch:
   - feed 10, idle 2 cycles, 01, idle, 11 -> y=1 on the 11 cycle;
   - with mask bits of symbol 1 = 00, feed 10,11,11 -> y=1;
   - feed 10,00,11 with full mask -> y=0.
5. Saturation and clear: CNT_W=2, overlap=1, pattern 11,11,11, feed seven 11 symbols -> match_cnt sticks at 3. Assert cnt_clr in the same cycle as a match -> match_cnt=0.
6. Mid-operation events:
   - cfg_load in the same cycle as a would-be final symbol -> y=0, fill=0;
   - en=0 after two symbols, then en back via cfg_load -> the partial match is lost; 11 alone gives no match.

Source files
------------

// File: rtl/seq_detect_mealy_pkg.sv
// Shared types and helpers for the Mealy pattern detector.
// Holds the state encoding and the per-symbol masked compare.
package seq_detect_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  localparam int SYM_MAX_W = 32;

  // Inputs are zero-extended by the caller to SYM_MAX_W.
  function automatic logic sym_match(
    input logic [SYM_MAX_W-1:0] s,
    input logic [SYM_MAX_W-1:0] p,
    input logic [SYM_MAX_W-1:0] m
  );
    return ((s ^ p) & m) == '0;
  endfunction

endpackage

// File: rtl/seq_detect_mealy_if.sv
// Configuration, symbol stream and result bundle of the detector.
// master drives config/symbols, slave is the detector.
interface seq_detect_mealy_if #(
  parameter int SYM_W = 2,
  parameter int LEN   = 3,
  parameter int CNT_W = 8
);
  localparam int PW = LEN * SYM_W;
  localparam int FW = $clog2(LEN);

  logic          cfg_load;
  logic [PW-1:0] cfg_pattern;
  logic [PW-1:0] cfg_mask;
  logic          cfg_overlap;
  logic          en;
  logic          sym_valid;
  logic [SYM_W-1:0] sym;
  logic          cnt_clr;
  logic          y;
  logic          y_q;
  logic [FW-1:0] fill;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output cfg_load, cfg_pattern, cfg_mask, cfg_overlap,
    output en, sym_valid, sym, cnt_clr,
    input  y, y_q, fill, match_cnt
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_mask, cfg_overlap,
    input  en, sym_valid, sym, cnt_clr,
    output y, y_q, fill, match_cnt
  );
endinterface

// File: rtl/seq_hist_shreg.sv
// SYM_W x DEPTH history shift register, entry 0 oldest.
// Synchronous clear has priority over shift enable.
module seq_hist_shreg #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic [SYM_W-1:0]       din,
  output logic [DEPTH*SYM_W-1:0] q
);
  logic [DEPTH*SYM_W-1:0] nxt;

  generate
    if (DEPTH == 1) begin : g_one
      assign nxt = din;
    end else begin : g_many
      assign nxt = {din, q[DEPTH*SYM_W-1:SYM_W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end
endmodule

// File: rtl/seq_detect_mealy.sv
// Programmable masked Mealy sequence detector with arming,
// overlap control, registered match and saturating counter.
module seq_detect_mealy
  import seq_detect_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int LEN   = 3,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  seq_detect_mealy_if.slave bus
);
  localparam int PW = LEN * SYM_W;
  localparam int FW = $clog2(LEN);
  localparam int HD = LEN - 1;
  localparam logic [FW-1:0]    FILL_MAX = FW'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t state_q, state_d;
  logic [PW-1:0]    pat_q, mask_q;
  logic             ovl_q;
  logic [FW-1:0]    fill_q, fill_d;
  logic [HD*SYM_W-1:0] hist;
  logic [PW-1:0]    win;
  logic [LEN-1:0]   k_ok;
  logic             accept, y, hist_clr, y_q;
  logic [CNT_W-1:0] cnt_q;

  seq_hist_shreg #(
    .SYM_W(SYM_W),
    .DEPTH(HD)
  ) u_hist (
    .clk  (clk),
    .rst_n(rst),
    .clr  (hist_clr),
    .en   (accept),
    .din  (bus.sym),
    .q    (hist)
  );

  // Oldest symbol in the low bits, live symbol on top.
  assign win = {bus.sym, hist};

  always_comb begin
    k_ok = '0;
    for (int k = 0; k < LEN; k++) begin
      k_ok[k] = sym_match(
        SYM_MAX_W'(win[k*SYM_W +: SYM_W]),
        SYM_MAX_W'(pat_q[k*SYM_W +: SYM_W]),
        SYM_MAX_W'(mask_q[k*SYM_W +: SYM_W]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    accept   = 1'b0;
    y        = 1'b0;
    hist_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        fill_d   = '0;
        hist_clr = 1'b1;
        if (bus.cfg_load && bus.en) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        accept = bus.sym_valid && !bus.cfg_load;
        y = accept && (fill_q == FILL_MAX) && (&k_ok);
        if (!bus.en) begin
          state_d  = ST_IDLE;
          fill_d   = '0;
          hist_clr = 1'b1;
        end else if (bus.cfg_load) begin
          fill_d   = '0;
          hist_clr = 1'b1;
        end else if (accept) begin
          if (y && !ovl_q) begin
            fill_d = '0;
          end else if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= '0;
      mask_q <= '0;
      ovl_q  <= 1'b0;
    end else if (bus.cfg_load) begin
      pat_q  <= bus.cfg_pattern;
      mask_q <= bus.cfg_mask;
      ovl_q  <= bus.cfg_overlap;
    end
  end

  // Clear beats a coincident match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      fill_q <= fill_d;
      y_q    <= y;
      if (bus.cnt_clr) begin
        cnt_q <= '0;
      end else if (y && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.y         = y;
  assign bus.y_q       = y_q;
  assign bus.fill      = fill_q;
  assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_detect_mealy.sv
// Bench for seq_detect_mealy: directed plan steps then random
// traffic, checked against a queue-based reference model.
module tb_seq_detect_mealy;
  localparam int W = 2;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_detect_mealy_if #(.SYM_W(W), .LEN(L), .CNT_W(8)) bus ();
  seq_detect_mealy_if #(.SYM_W(W), .LEN(L), .CNT_W(2)) bus2 ();

  assign bus2.cfg_load    = bus.cfg_load;
  assign bus2.cfg_pattern = bus.cfg_pattern;
  assign bus2.cfg_mask    = bus.cfg_mask;
  assign bus2.cfg_overlap = bus.cfg_overlap;
  assign bus2.en          = bus.en;
  assign bus2.sym_valid   = bus.sym_valid;
  assign bus2.sym         = bus.sym;
  assign bus2.cnt_clr     = bus.cnt_clr;

  seq_detect_mealy #(.SYM_W(W), .LEN(L), .CNT_W(8)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  seq_detect_mealy #(.SYM_W(W), .LEN(L), .CNT_W(2)) u_sat (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  int tests = 0;
  int fails = 0;

  logic [L*W-1:0] c_pat, c_mask;
  logic c_ovl, c_en;

  logic [W-1:0] hq[$];
  bit m_armed, m_ovl, ey, m_yq;
  logic [L*W-1:0] m_pat, m_mask;
  int m_cnt, m_cnt2;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_y(input bit load, input bit valid,
                                 input logic [W-1:0] s);
    logic [W-1:0] w, p, m;
    if (!m_armed || !valid || load || hq.size() != L-1) return 1'b0;
    for (int k = 0; k < L; k++) begin
      if (k < L-1) w = hq[k];
      else w = s;
      p = m_pat[k*W +: W];
      m = m_mask[k*W +: W];
      if (((w ^ p) & m) != '0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_update(input bit load, input bit valid,
                              input logic [W-1:0] s, input bit clr);
    bit was;
    was = m_armed;
    if (!was || !c_en || load) hq.delete();
    else if (valid) begin
      if (ey && !m_ovl) hq.delete();
      else begin
        hq.push_back(s);
        if (hq.size() > L-1) void'(hq.pop_front());
      end
    end
    m_armed = was ? c_en : (load && c_en);
    if (load) begin
      m_pat = c_pat; m_mask = c_mask; m_ovl = c_ovl;
    end
    if (clr) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (ey) begin
      m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
      m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
    end
    m_yq = ey;
  endtask

  task automatic step(input bit load, input bit valid,
                      input logic [W-1:0] s, input bit clr);
    @(negedge clk);
    bus.cfg_load    = load;
    bus.cfg_pattern = c_pat;
    bus.cfg_mask    = c_mask;
    bus.cfg_overlap = c_ovl;
    bus.en          = c_en;
    bus.sym_valid   = valid;
    bus.sym         = s;
    bus.cnt_clr     = clr;
    #1;
    ey = model_y(load, valid, s);
    chk("y", 32'(bus.y), 32'(ey));
    chk("y_sat", 32'(bus2.y), 32'(ey));
    @(posedge clk);
    model_update(load, valid, s, clr);
    #1;
    chk("y_q", 32'(bus.y_q), 32'(m_yq));
    chk("fill", 32'(bus.fill), hq.size());
    chk("cnt", 32'(bus.match_cnt), m_cnt);
    chk("cnt_sat", 32'(bus2.match_cnt), m_cnt2);
  endtask

  task automatic model_reset();
    hq.delete();
    m_armed = 0; m_ovl = 0; m_yq = 0; ey = 0;
    m_pat = '0; m_mask = '0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_y", 32'(bus.y), 0);
    chk("rst_y_q", 32'(bus.y_q), 0);
    chk("rst_fill", 32'(bus.fill), 0);
    chk("rst_cnt", 32'(bus.match_cnt), 0);
    chk("rst_cnt_sat", 32'(bus2.match_cnt), 0);
    model_reset();
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    bit ld, vl, cl;
    logic [W-1:0] sv;
    bus.cfg_load = 0; bus.cfg_pattern = '0; bus.cfg_mask = '0;
    bus.cfg_overlap = 0; bus.en = 0; bus.sym_valid = 0;
    bus.sym = '0; bus.cnt_clr = 0;
    model_reset();
    c_pat = 6'b11_01_10; c_mask = '1; c_ovl = 0; c_en = 1;
    #12 rst = 1'b1;

    // 1: arm
    step(1, 0, 2'b00, 0);
    // 2: basic match, no overlap
    step(0, 1, 2'b10, 0);
    step(0, 1, 2'b01, 0);
    step(0, 1, 2'b11, 0);
    chk("t2_cnt", 32'(bus.match_cnt), 1);
    step(0, 0, 2'b00, 0);
    // 1: reset mid-stream, then re-arm
    step(0, 1, 2'b10, 0);
    step(0, 1, 2'b01, 0);
    do_reset();
    step(1, 0, 2'b00, 0);
    chk("t1_fill", 32'(bus.fill), 0);

    // 3: overlap on / off with 11,11,11
    c_pat = 6'b11_11_11; c_ovl = 1;
    step(1, 0, 2'b00, 1);
    repeat (6) step(0, 1, 2'b11, 0);
    chk("t3_ovl_cnt", 32'(bus.match_cnt), 4);
    c_ovl = 0;
    step(1, 0, 2'b00, 1);
    repeat (6) step(0, 1, 2'b11, 0);
    chk("t3_novl_cnt", 32'(bus.match_cnt), 2);

    // 4: gaps, masked symbol, mismatch
    c_pat = 6'b11_01_10; c_mask = '1;
    step(1, 0, 2'b00, 1);
    step(0, 1, 2'b10, 0);
    step(0, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0);
    step(0, 1, 2'b01, 0);
    step(0, 0, 2'b00, 0);
    step(0, 1, 2'b11, 0);
    chk("t4_gap_cnt", 32'(bus.match_cnt), 1);
    c_mask = 6'b11_00_11;
    step(1, 0, 2'b00, 1);
    step(0, 1, 2'b10, 0);
    step(0, 1, 2'b11, 0);
    step(0, 1, 2'b11, 0);
    chk("t4_mask_cnt", 32'(bus.match_cnt), 1);
    c_mask = '1;
    step(1, 0, 2'b00, 1);
    step(0, 1, 2'b10, 0);
    step(0, 1, 2'b00, 0);
    step(0, 1, 2'b11, 0);
    chk("t4_miss_cnt", 32'(bus.match_cnt), 0);

    // 5: saturation and clear-wins
    c_pat = 6'b11_11_11; c_ovl = 1;
    step(1, 0, 2'b00, 1);
    repeat (7) step(0, 1, 2'b11, 0);
    chk("t5_sat", 32'(bus2.match_cnt), 3);
    chk("t5_full", 32'(bus.match_cnt), 5);
    step(0, 1, 2'b11, 1);
    chk("t5_clr", 32'(bus2.match_cnt), 0);

    // 6: reload on final symbol, disarm drops partial match
    c_pat = 6'b11_01_10; c_ovl = 0;
    step(1, 0, 2'b00, 1);
    step(0, 1, 2'b10, 0);
    step(0, 1, 2'b01, 0);
    step(1, 1, 2'b11, 0);
    chk("t6_load_fill", 32'(bus.fill), 0);
    step(0, 1, 2'b10, 0);
    step(0, 1, 2'b01, 0);
    c_en = 0;
    step(0, 0, 2'b00, 0);
    c_en = 1;
    step(1, 0, 2'b00, 0);
    step(0, 1, 2'b11, 0);
    chk("t6_lost_cnt", 32'(bus.match_cnt), 0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      ld = ($urandom_range(0, 19) == 0) ||
           (!m_armed && $urandom_range(0, 2) == 0);
      if (ld) begin
        c_pat  = 6'($urandom);
        c_mask = ($urandom_range(0, 2) == 0) ? 6'($urandom) : '1;
        c_ovl  = ($urandom_range(0, 1) == 1);
      end
      c_en = ($urandom_range(0, 29) != 0);
      vl = ($urandom_range(0, 3) != 0);
      sv = 2'($urandom);
      cl = ($urandom_range(0, 49) == 0);
      step(ld, vl, sv, cl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
